curl_pow_multilane: RTL and testbench

Parametrised Curl-P proof-of-work engine: the successor of the single-lane PoW core. It runs NUM_LANES independent Curl states in parallel, each on a distinct nonce. It unrolls ROUNDS_PER_CYCLE rounds per clock, checks a numeric MWM, and adds abort and a batch limit. It sits behind the HPS register bridge; software writes the 9 I/O words, starts a transform or PoW, and reads back the result.

---
 rtl/curl_pow_multilane.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_curl_pow_multilane.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/curl_pow_multilane.sv
// Multi-lane Curl-P proof-of-work engine: NUM_LANES Curl states hashed in parallel,
// ROUNDS_PER_CYCLE rounds per clock, numeric MWM check, abort and batch limit.
module curl_pow_multilane #(
  parameter int unsigned NUM_LANES        = 1,
  parameter int unsigned NUM_ROUNDS       = 81,
  parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
  input  logic        i_clk,
  input  logic        i_arst_n,
  input  logic        i_we,
  input  logic [3:0]  i_addr,
  input  logic [53:0] i_data,
  input  logic        i_transform,
  input  logic        i_pow,
  input  logic        i_abort,
  input  logic [7:0]  i_mwm,
  input  logic [31:0] i_max_batches,
  output logic        o_busy,
  output logic        o_transforming,
  output logic        o_pow_hash_finish,
  output logic        o_pow_finish,
  output logic        o_pow_timeout,
  output logic [3:0]  o_found_lane,
  output logic [31:0] o_attempts,
  output logic [53:0] o_data
);

  localparam int unsigned TRITS    = 729;
  localparam int unsigned STATE_W  = 2 * TRITS;
  localparam int unsigned WORD_W   = 54;
  localparam int unsigned R        = NUM_ROUNDS / ROUNDS_PER_CYCLE;
  localparam int unsigned RND_W    = 7;
  localparam logic [RND_W-1:0] RND_LAST = RND_W'(R - 1);

  typedef enum logic [2:0] {IDLE, TRANSFORM, LOAD, HASH, CHECK} state_e;

  // Curl substitution box on encoded trits (00=0, 01=+1, 11=-1)
  function automatic logic [1:0] tbox(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] na, nb, r;
    na = (a == 2'b10) ? 2'b00 : a;
    nb = (b == 2'b10) ? 2'b00 : b;
    case ({na, nb})
      4'b1111: r = 2'b01;
      4'b0011: r = 2'b00;
      4'b0111: r = 2'b11;
      4'b1100: r = 2'b01;
      4'b0000: r = 2'b11;
      4'b0100: r = 2'b00;
      4'b1101: r = 2'b11;
      4'b0001: r = 2'b01;
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  function automatic logic [STATE_W-1:0] curl_round(input logic [STATE_W-1:0] s);
    logic [STATE_W-1:0] r;
    int unsigned idx, nidx;
    r   = '0;
    idx = 0;
    for (int i = 0; i < int'(TRITS); i++) begin
      nidx = (idx < 365) ? idx + 364 : idx - 365;
      r[2*i +: 2] = tbox(s[2*idx +: 2], s[2*nidx +: 2]);
      idx = nidx;
    end
    return r;
  endfunction

  function automatic logic [STATE_W-1:0] multi_round(input logic [STATE_W-1:0] s);
    logic [STATE_W-1:0] r;
    r = s;
    for (int k = 0; k < int'(ROUNDS_PER_CYCLE); k++) r = curl_round(r);
    return r;
  endfunction

  // Non-negative integer to a 27-trit balanced-ternary word, trit 0 least significant
  function automatic logic [WORD_W-1:0] bt_word(input int v);
    logic [WORD_W-1:0] w;
    int x;
    w = '0;
    x = v;
    for (int k = 0; k < 27; k++) begin
      if (x % 3 == 0) begin
        x = x / 3;
      end else if (x % 3 == 1) begin
        w[2*k +: 2] = 2'b01;
        x = (x - 1) / 3;
      end else begin
        w[2*k +: 2] = 2'b11;
        x = (x + 1) / 3;
      end
    end
    return w;
  endfunction

  // Balanced-ternary +1; all +1 wraps to all -1
  function automatic logic [WORD_W-1:0] tinc(input logic [WORD_W-1:0] c);
    logic [WORD_W-1:0] r;
    logic carry;
    r     = c;
    carry = 1'b1;
    for (int k = 0; k < 27; k++) begin
      if (carry) begin
        case (c[2*k +: 2])
          2'b00:   begin r[2*k +: 2] = 2'b01; carry = 1'b0; end
          2'b11:   begin r[2*k +: 2] = 2'b00; carry = 1'b0; end
          default: r[2*k +: 2] = 2'b11;
        endcase
      end
    end
    return r;
  endfunction

  function automatic logic lane_valid(input logic [STATE_W-1:0] s, input logic [7:0] mwm);
    logic ok;
    ok = 1'b1;
    for (int t = 0; t < 243; t++)
      if ((t + int'(mwm)) >= 243 && s[2*t +: 2] != 2'b00) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [STATE_W-1:0] load_state(input logic [STATE_W-1:0] mid, input int lane,
                                                    input logic [WORD_W-1:0] ctr);
    logic [STATE_W-1:0] r;
    r = mid;
    r[6*WORD_W +: WORD_W] = bt_word(lane);
    r[7*WORD_W +: WORD_W] = ctr;
    return r;
  endfunction

  state_e                 state_q, state_d;
  logic [RND_W-1:0]       rnd_q, rnd_d;
  logic [STATE_W-1:0]     lane_q   [NUM_LANES];
  logic [STATE_W-1:0]     lane_rnd [NUM_LANES];
  logic [STATE_W-1:0]     mid_q;
  logic [WORD_W-1:0]      ctr_q;
  logic [3*WORD_W-1:0]    nonce_q;
  logic [7:0]             mwm_cl;
  logic                   any_ok;
  logic [3:0]             found_c;
  logic [WORD_W-1:0]      found_bt;
  logic [31:0]            attempts_inc;
  logic                   timeout_hit;
  logic                   hash_fin_d, pow_fin_d, timeout_d;

  assign mwm_cl       = (i_mwm > 8'd243) ? 8'd243 : i_mwm;
  assign attempts_inc = (o_attempts == '1) ? o_attempts : o_attempts + 32'd1;
  assign timeout_hit  = (i_max_batches != '0) && (attempts_inc >= i_max_batches);

  // Round datapath and lowest-index valid-lane search
  always_comb begin
    lane_rnd = lane_q;
    any_ok   = 1'b0;
    found_c  = '0;
    found_bt = '0;
    for (int l = int'(NUM_LANES) - 1; l >= 0; l--) begin
      lane_rnd[l] = multi_round(lane_q[l]);
      if (lane_valid(lane_q[l], mwm_cl)) begin
        any_ok   = 1'b1;
        found_c  = 4'(l);
        found_bt = bt_word(l);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q <= IDLE;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rnd_d      = rnd_q;
    hash_fin_d = 1'b0;
    pow_fin_d  = 1'b0;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        rnd_d = '0;
        if (i_pow)            state_d = LOAD;
        else if (i_transform) state_d = TRANSFORM;
      end
      TRANSFORM: begin
        rnd_d = rnd_q + RND_W'(1);
        if (i_abort || rnd_q == RND_LAST) state_d = IDLE;
      end
      LOAD: begin
        rnd_d   = '0;
        state_d = i_abort ? IDLE : HASH;
      end
      HASH: begin
        rnd_d = rnd_q + RND_W'(1);
        if (i_abort) begin
          state_d = IDLE;
        end else if (rnd_q == RND_LAST) begin
          state_d    = CHECK;
          hash_fin_d = 1'b1;
        end
      end
      CHECK: begin
        if (i_abort) begin
          state_d = IDLE;
        end else if (any_ok) begin
          state_d   = IDLE;
          pow_fin_d = 1'b1;
        end else if (timeout_hit) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-lane Curl state registers; lane 0 is also the host-visible state
  for (genvar g = 0; g < int'(NUM_LANES); g++) begin : g_lane
    localparam bit IS_L0 = (g == 0);
    logic [STATE_W-1:0] st_q;
    assign lane_q[g] = st_q;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
        st_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (IS_L0 && i_we)
              for (int w = 0; w < 9; w++)
                if (i_addr == 4'(w)) st_q[w*WORD_W +: WORD_W] <= i_data;
          end
          TRANSFORM: if (IS_L0 && !i_abort) st_q <= lane_rnd[g];
          LOAD:      if (!i_abort) st_q <= load_state(mid_q, g, ctr_q);
          HASH:      if (!i_abort) st_q <= lane_rnd[g];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      o_busy            <= 1'b0;
      o_transforming    <= 1'b0;
      o_pow_hash_finish <= 1'b0;
      o_pow_finish      <= 1'b0;
      o_pow_timeout     <= 1'b0;
      o_found_lane      <= '0;
      o_attempts        <= '0;
      mid_q             <= '0;
      ctr_q             <= '0;
      nonce_q           <= '0;
    end else begin
      o_busy            <= (state_d != IDLE);
      o_transforming    <= (state_d == TRANSFORM);
      o_pow_hash_finish <= hash_fin_d;
      o_pow_finish      <= pow_fin_d;
      o_pow_timeout     <= timeout_d;
      if (state_q == IDLE && i_pow) begin
        mid_q      <= lane_q[0];
        ctr_q      <= '0;
        o_attempts <= '0;
      end
      if (state_q == CHECK && !i_abort) begin
        if (any_ok) begin
          o_found_lane <= found_c;
          nonce_q      <= {mid_q[8*WORD_W +: WORD_W], ctr_q, found_bt};
        end else begin
          o_attempts <= attempts_inc;
          ctr_q      <= tinc(ctr_q);
        end
      end
    end
  end

  // Host read mux
  always_comb begin
    o_data = '0;
    for (int w = 0; w < 6; w++)
      if (i_addr == 4'(w)) o_data = lane_q[0][w*WORD_W +: WORD_W];
    for (int w = 0; w < 3; w++)
      if (i_addr == 4'(w + 6)) o_data = nonce_q[w*WORD_W +: WORD_W];
  end

endmodule

// File: tb/tb_curl_pow_multilane.sv
// Directed bench for curl_pow_multilane: a default instance and a 3-lane,
// 3-rounds-per-cycle instance driven by the same host stimulus.
module tb_curl_pow_multilane;

  localparam logic [53:0] ALL_P = 54'h15_5555_5555_5555;
  localparam logic [53:0] ALL_M = 54'h3F_FFFF_FFFF_FFFF;

  logic        i_clk = 1'b0;
  logic        i_arst_n, i_we, i_transform, i_pow, i_abort;
  logic [3:0]  i_addr;
  logic [53:0] i_data;
  logic [7:0]  i_mwm;
  logic [31:0] i_max_batches;

  logic        busy_a, tr_a, hf_a, fin_a, to_a;
  logic [3:0]  lane_a;
  logic [31:0] att_a;
  logic [53:0] data_a;
  logic        busy_b, tr_b, hf_b, fin_b, to_b;
  logic [3:0]  lane_b;
  logic [31:0] att_b;
  logic [53:0] data_b;

  always #5 i_clk = ~i_clk;

  curl_pow_multilane u_dut (
    .i_clk(i_clk), .i_arst_n(i_arst_n), .i_we(i_we), .i_addr(i_addr), .i_data(i_data),
    .i_transform(i_transform), .i_pow(i_pow), .i_abort(i_abort), .i_mwm(i_mwm),
    .i_max_batches(i_max_batches), .o_busy(busy_a), .o_transforming(tr_a),
    .o_pow_hash_finish(hf_a), .o_pow_finish(fin_a), .o_pow_timeout(to_a),
    .o_found_lane(lane_a), .o_attempts(att_a), .o_data(data_a)
  );

  curl_pow_multilane #(.NUM_LANES(3), .NUM_ROUNDS(81), .ROUNDS_PER_CYCLE(3)) u_dut3 (
    .i_clk(i_clk), .i_arst_n(i_arst_n), .i_we(i_we), .i_addr(i_addr), .i_data(i_data),
    .i_transform(i_transform), .i_pow(i_pow), .i_abort(i_abort), .i_mwm(i_mwm),
    .i_max_batches(i_max_batches), .o_busy(busy_b), .o_transforming(tr_b),
    .o_pow_hash_finish(hf_b), .o_pow_finish(fin_b), .o_pow_timeout(to_b),
    .o_found_lane(lane_b), .o_attempts(att_b), .o_data(data_b)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int ms [729];
  int tt [9] = '{1, 0, -1, 1, -1, 0, -1, 1, 0};
  int ca, cb, fa, fb, hfa, nfin, nto, toa, tob, nh;
  int hcyc [4];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Software Curl-P reference on integer trits
  task automatic model_rounds(input int n);
    int nx [729];
    int idx, a, b;
    for (int r = 0; r < n; r++) begin
      idx = 0;
      for (int i = 0; i < 729; i++) begin
        a   = ms[idx];
        idx = (idx < 365) ? idx + 364 : idx - 365;
        b   = ms[idx];
        nx[i] = tt[a + 3*b + 4];
      end
      ms = nx;
    end
  endtask

  task automatic model_write(input int w, input logic [53:0] d);
    for (int k = 0; k < 27; k++)
      ms[27*w + k] = (d[2*k +: 2] == 2'b01) ? 1 : (d[2*k +: 2] == 2'b11) ? -1 : 0;
  endtask

  function automatic logic [53:0] model_word(input int w);
    logic [53:0] d;
    d = '0;
    for (int k = 0; k < 27; k++)
      d[2*k +: 2] = (ms[27*w + k] == 1) ? 2'b01 : (ms[27*w + k] == -1) ? 2'b11 : 2'b00;
    return d;
  endfunction

  task automatic write_word(input logic [3:0] a, input logic [53:0] d);
    i_we = 1'b1; i_addr = a; i_data = d;
    step();
    i_we = 1'b0;
  endtask

  task automatic run_transform();
    i_transform = 1'b1;
    step();
    i_transform = 1'b0;
    ca = int'(tr_a);
    cb = int'(tr_b);
    for (int n = 0; n < 200 && (tr_a || tr_b); n++) begin
      step();
      if (tr_a) ca++;
      if (tr_b) cb++;
    end
  endtask

  task automatic compare_words(input string tag);
    for (int w = 0; w < 6; w++) begin
      i_addr = 4'(w);
      #1;
      check($sformatf("%s_w%0d_a", tag, w), 64'(data_a), 64'(model_word(w)));
      check($sformatf("%s_w%0d_b", tag, w), 64'(data_b), 64'(model_word(w)));
    end
  endtask

  task automatic start_pow();
    i_pow = 1'b1;
    step();
    i_pow = 1'b0;
  endtask

  initial begin
    i_arst_n = 1'b0; i_we = 1'b0; i_addr = '0; i_data = '0;
    i_transform = 1'b0; i_pow = 1'b0; i_abort = 1'b0;
    i_mwm = '0; i_max_batches = '0;
    foreach (ms[i]) ms[i] = 0;
    step(); step();
    @(negedge i_clk) i_arst_n = 1'b1;
    step();

    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_transforming", 64'(tr_a), 64'd0);
    check("rst_attempts", 64'(att_a), 64'd0);
    check("rst_found_lane", 64'(lane_b), 64'd0);
    i_addr = 4'd0; #1;
    check("rst_data0", 64'(data_a), 64'd0);

    // plain transform of the all-zero state
    run_transform();
    check("tr0_cycles_a", 64'(ca), 64'd81);
    check("tr0_cycles_b", 64'(cb), 64'd27);
    model_rounds(81);
    compare_words("tr0");

    // transform after host writes
    write_word(4'd0, ALL_P);
    write_word(4'd3, ALL_M);
    model_write(0, ALL_P);
    model_write(3, ALL_M);
    run_transform();
    check("tr1_cycles_a", 64'(ca), 64'd81);
    model_rounds(81);
    compare_words("tr1");

    // PoW with mwm=0: first batch succeeds on lane 0
    write_word(4'd8, ALL_P);
    i_mwm = 8'd0; i_max_batches = 32'd0;
    start_pow();
    fa = -1; fb = -1; hfa = -1; nfin = 0;
    for (int n = 1; n <= 150; n++) begin
      step();
      if (fin_a) begin nfin++; if (fa < 0) fa = n; end
      if (fin_b && fb < 0) fb = n;
      if (hf_a && hfa < 0) hfa = n;
    end
    check("pow0_finish_cycle_a", 64'(fa), 64'd83);
    check("pow0_finish_cycle_b", 64'(fb), 64'd29);
    check("pow0_hash_finish_a", 64'(hfa), 64'd82);
    check("pow0_finish_width", 64'(nfin), 64'd1);
    check("pow0_lane_a", 64'(lane_a), 64'd0);
    check("pow0_lane_b", 64'(lane_b), 64'd0);
    check("pow0_attempts_a", 64'(att_a), 64'd0);
    check("pow0_busy_a", 64'(busy_a), 64'd0);
    i_addr = 4'd6; #1;
    check("pow0_nonce6_a", 64'(data_a), 64'd0);
    check("pow0_nonce6_b", 64'(data_b), 64'd0);
    i_addr = 4'd7; #1;
    check("pow0_nonce7_a", 64'(data_a), 64'd0);
    i_addr = 4'd8; #1;
    check("pow0_nonce8_a", 64'(data_a), 64'(ALL_P));
    check("pow0_nonce8_b", 64'(data_b), 64'(ALL_P));

    // batch limit with an unreachable MWM
    i_mwm = 8'd243; i_max_batches = 32'd3;
    start_pow();
    nh = 0; toa = -1; tob = -1; nto = 0; nfin = 0;
    for (int n = 1; n <= 300; n++) begin
      step();
      if (hf_a) begin if (nh < 4) hcyc[nh] = n; nh++; end
      if (to_a) begin nto++; if (toa < 0) toa = n; end
      if (to_b && tob < 0) tob = n;
      if (fin_a || fin_b) nfin++;
    end
    check("to_hash_count", 64'(nh), 64'd3);
    check("to_hash0", 64'(hcyc[0]), 64'd82);
    check("to_hash1", 64'(hcyc[1]), 64'd165);
    check("to_hash2", 64'(hcyc[2]), 64'd248);
    check("to_timeout_cycle_a", 64'(toa), 64'd249);
    check("to_timeout_width", 64'(nto), 64'd1);
    check("to_timeout_cycle_b", 64'(tob), 64'd87);
    check("to_no_finish", 64'(nfin), 64'd0);
    check("to_attempts_a", 64'(att_a), 64'd3);
    check("to_attempts_b", 64'(att_b), 64'd3);
    check("to_busy_a", 64'(busy_a), 64'd0);

    // abort mid-batch; mwm above 243 is clamped
    i_mwm = 8'd255; i_max_batches = 32'd0;
    start_pow();
    nfin = 0;
    for (int n = 1; n <= 101; n++) begin
      if (n == 100) i_abort = 1'b1;
      step();
      i_abort = 1'b0;
      if (fin_a || fin_b || to_a || to_b) nfin++;
    end
    check("ab_busy_a", 64'(busy_a), 64'd0);
    check("ab_busy_b", 64'(busy_b), 64'd0);
    check("ab_no_pulses", 64'(nfin), 64'd0);
    check("ab_attempts_a", 64'(att_a), 64'd1);
    check("ab_attempts_b", 64'(att_b), 64'd3);
    i_transform = 1'b1;
    step();
    i_transform = 1'b0;
    check("ab_new_transform", 64'(tr_a), 64'd1);
    for (int n = 0; n < 200 && (busy_a || busy_b); n++) step();
    check("ab_transform_done", 64'(busy_a), 64'd0);

    // asynchronous reset during PoW
    i_mwm = 8'd243;
    start_pow();
    for (int n = 1; n <= 40; n++) step();
    check("rs_busy_before", 64'(busy_a), 64'd1);
    #1 i_arst_n = 1'b0;
    #1;
    check("rs_busy", 64'(busy_a), 64'd0);
    check("rs_busy_b", 64'(busy_b), 64'd0);
    check("rs_pulses", 64'({tr_a, hf_a, fin_a, to_a}), 64'd0);
    check("rs_attempts", 64'(att_a), 64'd0);
    check("rs_found_lane", 64'(lane_a), 64'd0);
    for (int w = 0; w < 9; w++) begin
      i_addr = 4'(w);
      #1;
      check($sformatf("rs_data%0d", w), 64'(data_a), 64'd0);
    end
    @(negedge i_clk) i_arst_n = 1'b1;
    step();
    check("rs_idle_after", 64'(busy_a), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
